// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern generator.
// A start request in IDLE latches a PAT_W-bit pattern (the input pattern or
// PAT_DEFAULT) and a repeat count. The pattern is then sent MSB first, one
// bit per clock, repeat_cnt times with no gap between repetitions.
// A one-cycle done pulse follows the burst.
//
// Optional build macro: SEQ_GEN_PARITY_EN
//   defined     - an even-parity bit (XOR of the pattern) follows each repetition
//   not defined - pattern bits only
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start        burst request, sampled only in IDLE
//   use_default  1: send PAT_DEFAULT, 0: send pattern
//   pattern      pattern to send, latched at an accepted start
//   repeat_cnt   number of repetitions, latched at an accepted start
//   out          serial data bit (0 whenever valid is low)
//   valid        out carries a stream bit this cycle
//   busy         state is not IDLE
//   done         one-cycle pulse at the end of a burst
//
// state | meaning
// IDLE  | waiting for start
// SEND  | shifting out pattern bits
// PAR   | parity bit after a repetition (SEQ_GEN_PARITY_EN only)
// DONE  | one-cycle end-of-burst pulse
module seq_pattern_gen #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1100,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int              BC_W     = $clog2(PAT_W);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(PAT_W - 1);

`ifdef SEQ_GEN_PARITY_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2,
        PAR  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

    state_t            state, state_nxt;
    logic [PAT_W-1:0]  pat_reg, pat_nxt;
    logic [CNT_W-1:0]  rep, rep_nxt;
    logic [BC_W-1:0]   bit_cnt, bit_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pat_reg <= '0;
            rep     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pat_reg <= pat_nxt;
            rep     <= rep_nxt;
            bit_cnt <= bit_nxt;
        end
    end

    // Outputs decode only the registered state and pattern register.
    always_comb begin
        state_nxt = state;
        pat_nxt   = pat_reg;
        rep_nxt   = rep;
        bit_nxt   = bit_cnt;
        out       = 1'b0;
        valid     = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    pat_nxt   = use_default ? PAT_DEFAULT : pattern;
                    rep_nxt   = repeat_cnt;
                    bit_nxt   = BIT_LAST;
                    state_nxt = (repeat_cnt != '0) ? SEND : DONE;
                end
            end

            SEND: begin
                out     = pat_reg[PAT_W-1];
                valid   = 1'b1;
                // A full rotation brings the pattern back for the next repetition.
                pat_nxt = {pat_reg[PAT_W-2:0], pat_reg[PAT_W-1]};
                if (bit_cnt == '0) begin
                    bit_nxt = BIT_LAST;
`ifdef SEQ_GEN_PARITY_EN
                    state_nxt = PAR;
`else
                    rep_nxt = rep - 1'b1;
                    if (rep == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
`endif
                end else begin
                    bit_nxt = bit_cnt - 1'b1;
                end
            end

`ifdef SEQ_GEN_PARITY_EN
            PAR: begin
                out       = ^pat_reg;
                valid     = 1'b1;
                rep_nxt   = rep - 1'b1;
                state_nxt = (rep == CNT_W'(1)) ? DONE : SEND;
            end
`endif

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
